pipe_regs: RTL and testbench
============================

PIPE_REGS -- requirements
Module: pipe_regs

Parameters
REQ-001 The block SHALL have parameter NOP_ICODE, default 4'd1, giving the icode loaded on a bubble.
REQ-002 The block SHALL have parameter RNONE, default 4'hF, giving the register ID loaded into every register-ID field on a bubble.
REQ-003 The block SHALL have parameter STAT_AOK, default 4'd1, giving the stat loaded on a bubble.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports F_stall, D_stall and W_stall, inputs, 1 bit each: hold the F, D and W registers respectively.
REQ-007 The block SHALL have ports D_bubble, E_bubble and M_bubble, inputs, 1 bit each: load a bubble into the D, E and M registers respectively.
REQ-008 The block SHALL have port f_predPC, input, 64 bits, and port F_predPC, output, 64 bits: next and registered predicted PC.
REQ-009 The block SHALL have inputs f_stat, f_icode, f_ifun, f_rA, f_rB (4 bits each) and f_valC, f_valP (64 bits each), and the matching registered outputs D_*.
REQ-010 The block SHALL have inputs d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB (4 bits each) and d_valC, d_valA, d_valB (64 bits each), and the matching registered outputs E_*.
REQ-011 The block SHALL have inputs e_stat, e_icode, e_dstE, e_dstM (4 bits each), e_Cnd (1 bit) and e_valE, e_valA (64 bits each), and the matching registered outputs M_*.
REQ-012 The block SHALL have inputs m_stat, m_icode, m_dstE, m_dstM (4 bits each) and m_valE, m_valM (64 bits each), and the matching registered outputs W_*.
REQ-013 The block SHALL have ports bubble_cnt and stall_cnt, outputs, 32 bits each: performance counters.

Function
REQ-014 The block SHALL update each stage register at a clock edge with exactly one action: stall (hold), bubble (load bubble) or normal (load the stage inputs), giving a latency of 1 cycle from input to output.
REQ-015 The block SHALL give stall priority over bubble when both are asserted for the same stage in the same cycle.
REQ-016 The block SHALL define a bubble as: stat=STAT_AOK, icode=NOP_ICODE, ifun=0, every register-ID field=RNONE, every value field=0 and Cnd=0.
REQ-017 The F register SHALL have a stall input only (F_stall): F_predPC SHALL hold when F_stall=1 and SHALL load f_predPC otherwise.
REQ-018 The D register SHALL follow D_stall then D_bubble, in that priority.
REQ-019 The E register SHALL have a bubble input only (E_bubble).
REQ-020 The M register SHALL have a bubble input only (M_bubble).
REQ-021 The W register SHALL have a stall input only (W_stall).
REQ-022 The block SHALL set halted=1 on the edge at which W loads an m_stat other than STAT_AOK; halted SHALL be sticky until rst.
REQ-023 While halted=1, all five registers SHALL hold regardless of the control inputs.
REQ-024 The block SHALL increment bubble_cnt by the number of bubbles actually loaded that cycle (0 to 3).
REQ-025 The block SHALL increment stall_cnt by 1 on each cycle in which at least one stall is applied.
REQ-026 The counters SHALL wrap modulo 2^32 and SHALL freeze while halted=1.
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-028 When rst=1, the block SHALL immediately (asynchronously) set F_predPC=0, load D, E, M and W with the bubble, and clear halted, bubble_cnt and stall_cnt.
REQ-029 An rst asserted mid-operation SHALL override any stall, bubble or halted condition; normal loading SHALL resume on the first rising clk edge after rst deasserts.

Verification
REQ-030 Reset scenario: assert rst between clock edges -> all outputs take their reset values (REQ-028) before the next edge: W_icode=1, W_dstE=4'hF, F_predPC=0.
REQ-031 Normal flow scenario: drive f_icode=3, f_valC=0x10 with all controls low -> D_icode=3 after 1 edge; d_icode=3 presented next cycle -> E_icode=3 after 2 edges.
REQ-032 Load-use scenario: F_stall=D_stall=E_bubble=1 for 1 cycle -> F_predPC and D_* hold, E_icode=1, E_dstM=4'hF, bubble_cnt+1, stall_cnt+1.
REQ-033 Mispredict scenario: D_bubble=E_bubble=1 -> D_icode=1 and E_icode=1 next cycle, bubble_cnt+2; with D_stall=D_bubble=1, D holds.
REQ-034 Halt scenario: m_stat=2 -> W_stat=2 and halted=1; then toggle all controls for 5 cycles -> no register or counter changes; rst clears.
REQ-035 Wrap scenario: preset bubble_cnt to 32'hFFFFFFFF via a forced state, apply 2 bubbles -> bubble_cnt=1.

Source files
------------

// File: rtl/pipe_regs_if.sv
// Stage-to-stage bundle for the five pipeline registers:
// stage inputs, registered outputs, hazard controls and counters.
interface pipe_regs_if;
    logic        F_stall;
    logic        D_stall;
    logic        W_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic        M_bubble;

    logic [63:0] f_predPC;
    logic [63:0] F_predPC;

    logic [3:0]  f_stat;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [3:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    logic [3:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;

    logic [3:0]  e_stat;
    logic [3:0]  e_icode;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  M_stat;
    logic [3:0]  M_icode;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;

    logic [3:0]  m_stat;
    logic [3:0]  m_icode;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;

    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;
    logic        halted;

    modport master (
        output F_stall, D_stall, W_stall,
        output D_bubble, E_bubble, M_bubble,
        output f_predPC,
        output f_stat, f_icode, f_ifun, f_rA, f_rB,
        output f_valC, f_valP,
        output d_stat, d_icode, d_ifun, d_dstE, d_dstM,
        output d_srcA, d_srcB, d_valC, d_valA, d_valB,
        output e_stat, e_icode, e_dstE, e_dstM,
        output e_Cnd, e_valE, e_valA,
        output m_stat, m_icode, m_dstE, m_dstM,
        output m_valE, m_valM,
        input  F_predPC,
        input  D_stat, D_icode, D_ifun, D_rA, D_rB,
        input  D_valC, D_valP,
        input  E_stat, E_icode, E_ifun, E_dstE, E_dstM,
        input  E_srcA, E_srcB, E_valC, E_valA, E_valB,
        input  M_stat, M_icode, M_dstE, M_dstM,
        input  M_Cnd, M_valE, M_valA,
        input  W_stat, W_icode, W_dstE, W_dstM,
        input  W_valE, W_valM,
        input  bubble_cnt, stall_cnt, halted
    );

    modport slave (
        input  F_stall, D_stall, W_stall,
        input  D_bubble, E_bubble, M_bubble,
        input  f_predPC,
        input  f_stat, f_icode, f_ifun, f_rA, f_rB,
        input  f_valC, f_valP,
        input  d_stat, d_icode, d_ifun, d_dstE, d_dstM,
        input  d_srcA, d_srcB, d_valC, d_valA, d_valB,
        input  e_stat, e_icode, e_dstE, e_dstM,
        input  e_Cnd, e_valE, e_valA,
        input  m_stat, m_icode, m_dstE, m_dstM,
        input  m_valE, m_valM,
        output F_predPC,
        output D_stat, D_icode, D_ifun, D_rA, D_rB,
        output D_valC, D_valP,
        output E_stat, E_icode, E_ifun, E_dstE, E_dstM,
        output E_srcA, E_srcB, E_valC, E_valA, E_valB,
        output M_stat, M_icode, M_dstE, M_dstM,
        output M_Cnd, M_valE, M_valA,
        output W_stat, W_icode, W_dstE, W_dstM,
        output W_valE, W_valM,
        output bubble_cnt, stall_cnt, halted
    );
endinterface

// File: rtl/pipe_regs.sv
// F/D/E/M/W pipeline registers with stall/bubble control,
// sticky halt on a faulting writeback and hazard counters.
module pipe_regs #(
    parameter logic [3:0] NOP_ICODE = 4'd1,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [3:0] STAT_AOK  = 4'd1
) (
    input  logic      clk,
    input  logic      rst,
    pipe_regs_if.slave p
);
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] val_c;
        logic [63:0] val_p;
    } d_reg_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [63:0] val_c;
        logic [63:0] val_a;
        logic [63:0] val_b;
    } e_reg_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_a;
    } m_reg_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_m;
    } w_reg_t;

    localparam d_reg_t D_BUB = '{
        stat: STAT_AOK, icode: NOP_ICODE, ifun: 4'd0,
        ra: RNONE, rb: RNONE,
        val_c: 64'd0, val_p: 64'd0
    };
    localparam e_reg_t E_BUB = '{
        stat: STAT_AOK, icode: NOP_ICODE, ifun: 4'd0,
        dst_e: RNONE, dst_m: RNONE,
        src_a: RNONE, src_b: RNONE,
        val_c: 64'd0, val_a: 64'd0, val_b: 64'd0
    };
    localparam m_reg_t M_BUB = '{
        stat: STAT_AOK, icode: NOP_ICODE, cnd: 1'b0,
        dst_e: RNONE, dst_m: RNONE,
        val_e: 64'd0, val_a: 64'd0
    };
    localparam w_reg_t W_BUB = '{
        stat: STAT_AOK, icode: NOP_ICODE,
        dst_e: RNONE, dst_m: RNONE,
        val_e: 64'd0, val_m: 64'd0
    };

    logic [63:0] pc_q, pc_n;
    d_reg_t      d_q, d_n, d_in;
    e_reg_t      e_q, e_n, e_in;
    m_reg_t      m_q, m_n, m_in;
    w_reg_t      w_q, w_n, w_in;
    logic        halted_q, halted_n;
    logic [31:0] bubble_cnt_q, bubble_cnt_n;
    logic [31:0] stall_cnt_q, stall_cnt_n;
    logic        d_bub, e_bub, m_bub, any_stall;
    logic [1:0]  n_bub;

    assign d_in = '{
        stat: p.f_stat, icode: p.f_icode, ifun: p.f_ifun,
        ra: p.f_rA, rb: p.f_rB,
        val_c: p.f_valC, val_p: p.f_valP
    };
    assign e_in = '{
        stat: p.d_stat, icode: p.d_icode, ifun: p.d_ifun,
        dst_e: p.d_dstE, dst_m: p.d_dstM,
        src_a: p.d_srcA, src_b: p.d_srcB,
        val_c: p.d_valC, val_a: p.d_valA, val_b: p.d_valB
    };
    assign m_in = '{
        stat: p.e_stat, icode: p.e_icode, cnd: p.e_Cnd,
        dst_e: p.e_dstE, dst_m: p.e_dstM,
        val_e: p.e_valE, val_a: p.e_valA
    };
    assign w_in = '{
        stat: p.m_stat, icode: p.m_icode,
        dst_e: p.m_dstE, dst_m: p.m_dstM,
        val_e: p.m_valE, val_m: p.m_valM
    };

    // A D bubble masked by D_stall is not a bubble actually loaded.
    always_comb begin
        d_bub     = ~halted_q & p.D_bubble & ~p.D_stall;
        e_bub     = ~halted_q & p.E_bubble;
        m_bub     = ~halted_q & p.M_bubble;
        any_stall = ~halted_q & (p.F_stall | p.D_stall | p.W_stall);
        n_bub     = {1'b0, d_bub} + {1'b0, e_bub} + {1'b0, m_bub};
    end

    always_comb begin
        pc_n     = pc_q;
        d_n      = d_q;
        e_n      = e_q;
        m_n      = m_q;
        w_n      = w_q;
        halted_n = halted_q;
        if (!halted_q) begin
            if (!p.F_stall) pc_n = p.f_predPC;
            if (!p.D_stall) d_n = p.D_bubble ? D_BUB : d_in;
            e_n = p.E_bubble ? E_BUB : e_in;
            m_n = p.M_bubble ? M_BUB : m_in;
            if (!p.W_stall) begin
                w_n      = w_in;
                halted_n = (p.m_stat != STAT_AOK);
            end
        end
    end

    always_comb begin
        bubble_cnt_n = bubble_cnt_q + {30'd0, n_bub};
        stall_cnt_n  = stall_cnt_q + {31'd0, any_stall};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= 64'd0;
            d_q      <= D_BUB;
            e_q      <= E_BUB;
            m_q      <= M_BUB;
            w_q      <= W_BUB;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_n;
            d_q      <= d_n;
            e_q      <= e_n;
            m_q      <= m_n;
            w_q      <= w_n;
            halted_q <= halted_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else if (!halted_q) begin
            bubble_cnt_q <= bubble_cnt_n;
            stall_cnt_q  <= stall_cnt_n;
        end
    end

    assign p.F_predPC = pc_q;

    assign p.D_stat  = d_q.stat;
    assign p.D_icode = d_q.icode;
    assign p.D_ifun  = d_q.ifun;
    assign p.D_rA    = d_q.ra;
    assign p.D_rB    = d_q.rb;
    assign p.D_valC  = d_q.val_c;
    assign p.D_valP  = d_q.val_p;

    assign p.E_stat  = e_q.stat;
    assign p.E_icode = e_q.icode;
    assign p.E_ifun  = e_q.ifun;
    assign p.E_dstE  = e_q.dst_e;
    assign p.E_dstM  = e_q.dst_m;
    assign p.E_srcA  = e_q.src_a;
    assign p.E_srcB  = e_q.src_b;
    assign p.E_valC  = e_q.val_c;
    assign p.E_valA  = e_q.val_a;
    assign p.E_valB  = e_q.val_b;

    assign p.M_stat  = m_q.stat;
    assign p.M_icode = m_q.icode;
    assign p.M_Cnd   = m_q.cnd;
    assign p.M_dstE  = m_q.dst_e;
    assign p.M_dstM  = m_q.dst_m;
    assign p.M_valE  = m_q.val_e;
    assign p.M_valA  = m_q.val_a;

    assign p.W_stat  = w_q.stat;
    assign p.W_icode = w_q.icode;
    assign p.W_dstE  = w_q.dst_e;
    assign p.W_dstM  = w_q.dst_m;
    assign p.W_valE  = w_q.val_e;
    assign p.W_valM  = w_q.val_m;

    assign p.bubble_cnt = bubble_cnt_q;
    assign p.stall_cnt  = stall_cnt_q;
    assign p.halted     = halted_q;
endmodule

// File: tb/tb_pipe_regs.sv
// Scoreboard bench for pipe_regs: expectations queued with
// each stimulus step and compared after the following edge.
module tb_pipe_regs;
    logic clk;
    logic rst;

    pipe_regs_if bus ();

    pipe_regs dut (
        .clk (clk),
        .rst (rst),
        .p   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [4:0] {
        S_PC, S_DIC, S_DVC, S_DRA, S_EIC, S_EDM,
        S_MIC, S_MVE, S_WIC, S_WDE, S_WST,
        S_BCNT, S_SCNT, S_HALT
    } sel_e;

    typedef struct packed {
        sel_e        sel;
        logic [63:0] exp;
    } sb_t;

    sb_t   sb_q[$];
    int    n_run;
    int    n_fail;
    string phase;

    function automatic string sname(sel_e s);
        case (s)
            S_PC:    return "F_predPC";
            S_DIC:   return "D_icode";
            S_DVC:   return "D_valC";
            S_DRA:   return "D_rA";
            S_EIC:   return "E_icode";
            S_EDM:   return "E_dstM";
            S_MIC:   return "M_icode";
            S_MVE:   return "M_valE";
            S_WIC:   return "W_icode";
            S_WDE:   return "W_dstE";
            S_WST:   return "W_stat";
            S_BCNT:  return "bubble_cnt";
            S_SCNT:  return "stall_cnt";
            default: return "halted";
        endcase
    endfunction

    function automatic logic [63:0] obs(sel_e s);
        case (s)
            S_PC:    return bus.F_predPC;
            S_DIC:   return {60'd0, bus.D_icode};
            S_DVC:   return bus.D_valC;
            S_DRA:   return {60'd0, bus.D_rA};
            S_EIC:   return {60'd0, bus.E_icode};
            S_EDM:   return {60'd0, bus.E_dstM};
            S_MIC:   return {60'd0, bus.M_icode};
            S_MVE:   return bus.M_valE;
            S_WIC:   return {60'd0, bus.W_icode};
            S_WDE:   return {60'd0, bus.W_dstE};
            S_WST:   return {60'd0, bus.W_stat};
            S_BCNT:  return {32'd0, bus.bubble_cnt};
            S_SCNT:  return {32'd0, bus.stall_cnt};
            default: return {63'd0, bus.halted};
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s got=%0h exp=%0h",
                     phase, tag, got, exp);
        end
    endtask

    task automatic expect_v(sel_e s, logic [63:0] v);
        sb_q.push_back('{sel: s, exp: v});
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(sname(e.sel), obs(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic ctl(logic fs, logic ds, logic ws,
                       logic db, logic eb, logic mb);
        bus.F_stall  = fs;
        bus.D_stall  = ds;
        bus.W_stall  = ws;
        bus.D_bubble = db;
        bus.E_bubble = eb;
        bus.M_bubble = mb;
    endtask

    task automatic zero_inputs();
        ctl(0, 0, 0, 0, 0, 0);
        bus.f_predPC = '0;
        bus.f_stat = 4'd1; bus.f_icode = '0; bus.f_ifun = '0;
        bus.f_rA = '0; bus.f_rB = '0;
        bus.f_valC = '0; bus.f_valP = '0;
        bus.d_stat = 4'd1; bus.d_icode = '0; bus.d_ifun = '0;
        bus.d_dstE = '0; bus.d_dstM = '0;
        bus.d_srcA = '0; bus.d_srcB = '0;
        bus.d_valC = '0; bus.d_valA = '0; bus.d_valB = '0;
        bus.e_stat = 4'd1; bus.e_icode = '0;
        bus.e_dstE = '0; bus.e_dstM = '0; bus.e_Cnd = 1'b0;
        bus.e_valE = '0; bus.e_valA = '0;
        bus.m_stat = 4'd1; bus.m_icode = '0;
        bus.m_dstE = '0; bus.m_dstM = '0;
        bus.m_valE = '0; bus.m_valM = '0;
    endtask

    task automatic expect_reset();
        expect_v(S_PC, 64'd0);
        expect_v(S_DIC, 64'd1);
        expect_v(S_DRA, 64'hF);
        expect_v(S_EIC, 64'd1);
        expect_v(S_EDM, 64'hF);
        expect_v(S_MIC, 64'd1);
        expect_v(S_WIC, 64'd1);
        expect_v(S_WDE, 64'hF);
        expect_v(S_WST, 64'd1);
        expect_v(S_BCNT, 64'd0);
        expect_v(S_SCNT, 64'd0);
        expect_v(S_HALT, 64'd0);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b0;
        zero_inputs();

        phase = "reset";
        #2 rst = 1'b1;
        #1;
        expect_reset();
        drain();
        @(posedge clk);
        #1 rst = 1'b0;

        phase = "flow1";
        bus.f_icode = 4'd3; bus.f_valC = 64'h10;
        bus.f_predPC = 64'h100; bus.f_rA = 4'd2;
        expect_v(S_DIC, 64'd3);
        expect_v(S_DVC, 64'h10);
        expect_v(S_DRA, 64'd2);
        expect_v(S_PC, 64'h100);
        step();

        phase = "flow2";
        bus.d_icode = 4'd3; bus.d_dstM = 4'd5;
        bus.f_icode = 4'd4; bus.f_predPC = 64'h108;
        expect_v(S_EIC, 64'd3);
        expect_v(S_EDM, 64'd5);
        expect_v(S_DIC, 64'd4);
        expect_v(S_PC, 64'h108);
        expect_v(S_BCNT, 64'd0);
        expect_v(S_SCNT, 64'd0);
        step();

        phase = "loaduse";
        ctl(1, 1, 0, 0, 1, 0);
        bus.f_icode = 4'd6; bus.f_predPC = 64'h200;
        bus.d_icode = 4'd7;
        expect_v(S_PC, 64'h108);
        expect_v(S_DIC, 64'd4);
        expect_v(S_EIC, 64'd1);
        expect_v(S_EDM, 64'hF);
        expect_v(S_BCNT, 64'd1);
        expect_v(S_SCNT, 64'd1);
        step();

        phase = "mispred";
        ctl(0, 0, 0, 1, 1, 0);
        expect_v(S_PC, 64'h200);
        expect_v(S_DIC, 64'd1);
        expect_v(S_DRA, 64'hF);
        expect_v(S_EIC, 64'd1);
        expect_v(S_BCNT, 64'd3);
        expect_v(S_SCNT, 64'd1);
        step();

        phase = "dload";
        ctl(0, 0, 0, 0, 0, 0);
        bus.f_icode = 4'd8;
        expect_v(S_DIC, 64'd8);
        expect_v(S_BCNT, 64'd3);
        step();

        phase = "dstall_bub";
        ctl(0, 1, 0, 1, 0, 0);
        bus.f_icode = 4'd9;
        expect_v(S_DIC, 64'd8);
        expect_v(S_BCNT, 64'd3);
        expect_v(S_SCNT, 64'd2);
        step();

        phase = "mbubble";
        ctl(0, 0, 0, 0, 0, 1);
        bus.e_icode = 4'd5; bus.e_valE = 64'h55;
        bus.m_icode = 4'd6;
        expect_v(S_MIC, 64'd1);
        expect_v(S_MVE, 64'd0);
        expect_v(S_WIC, 64'd6);
        expect_v(S_BCNT, 64'd4);
        step();

        phase = "mload";
        ctl(0, 0, 0, 0, 0, 0);
        expect_v(S_MIC, 64'd5);
        expect_v(S_MVE, 64'h55);
        step();

        phase = "wstall";
        ctl(0, 0, 1, 0, 0, 0);
        bus.m_icode = 4'd7;
        expect_v(S_WIC, 64'd6);
        expect_v(S_SCNT, 64'd3);
        step();

        phase = "wrap";
        ctl(0, 0, 0, 1, 1, 0);
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.bubble_cnt_q;
        expect_v(S_BCNT, 64'd1);
        expect_v(S_SCNT, 64'd3);
        step();

        phase = "halt";
        ctl(0, 0, 0, 0, 0, 0);
        bus.m_stat = 4'd2;
        bus.f_predPC = 64'h300; bus.f_icode = 4'hA;
        bus.d_icode = 4'hB; bus.e_icode = 4'hC;
        expect_v(S_WST, 64'd2);
        expect_v(S_HALT, 64'd1);
        expect_v(S_PC, 64'h300);
        expect_v(S_DIC, 64'hA);
        expect_v(S_EIC, 64'hB);
        expect_v(S_MIC, 64'hC);
        expect_v(S_BCNT, 64'd1);
        step();

        phase = "halted_hold";
        for (int i = 0; i < 5; i++) begin
            ctl(1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
            bus.m_stat = 4'($urandom);
            bus.f_predPC = 64'h400 + 64'(i);
            bus.f_icode = 4'd2; bus.d_icode = 4'd3;
            bus.e_icode = 4'd4; bus.m_icode = 4'd5;
            expect_v(S_PC, 64'h300);
            expect_v(S_DIC, 64'hA);
            expect_v(S_EIC, 64'hB);
            expect_v(S_MIC, 64'hC);
            expect_v(S_WST, 64'd2);
            expect_v(S_HALT, 64'd1);
            expect_v(S_BCNT, 64'd1);
            expect_v(S_SCNT, 64'd3);
            step();
        end

        phase = "halt_reset";
        #2 rst = 1'b1;
        #1;
        expect_reset();
        drain();
        #1 rst = 1'b0;

        phase = "resume";
        ctl(0, 0, 0, 0, 0, 0);
        bus.m_stat = 4'd1;
        bus.f_icode = 4'd3; bus.f_predPC = 64'h500;
        expect_v(S_DIC, 64'd3);
        expect_v(S_PC, 64'h500);
        expect_v(S_HALT, 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
